gen_rr_arb: RTL and testbench
=============================

// Module: gen_rr_arb
// PURPOSE
//  Round-robin arbiter with grant lock and optional starvation guard. Issues a registered
//  one-hot grant plus its binary index to N requesters. gnt_idx comes from an internal
//  gen_enc_top instance. Sits upstream of mux/select logic that consumes gnt_idx.
// PARAMETERS
//  N_REQ    4  number of requesters (>=2)
//  MAX_HOLD 0  max consecutive grant cycles per owner; 0 = no limit (lock until req drops)
//  IDX_W    $clog2(N_REQ) (localparam)  width of gnt_idx
// PORTS
//  clk      in   1      clock, all state on rising edge
//  rst_n    in   1      asynchronous active-low reset
//  req      in   N_REQ  request vector, level; bit i = requester i
//  gnt      out  N_REQ  registered one-hot grant; all-zero when no owner
//  gnt_vld  out  1      registered, = |gnt
//  gnt_idx  out  IDX_W  encoded gnt (gen_enc_top); 0 when gnt_vld=0
//  gnt_frc  out  1      registered 1-cycle pulse: previous grant ended by MAX_HOLD expiry
// BEHAVIOUR
//  Reset: gnt=0, gnt_vld=0, gnt_idx=0, gnt_frc=0, state=IDLE, ptr=0, hold_cnt=0.
//   Async assert clears these at once; first arbitration is on the first edge after deassert.
//  State: IDLE (no owner), BUSY (owner = index of gnt).
//  Arbitration: search req circularly from ptr upward; first set bit wins.
//   ptr = owner+1 mod N_REQ, updated on every release. Owner ends up lowest priority.
//  IDLE: edge with |req=1 -> gnt=winner one-hot, BUSY, hold_cnt=0. 1-cycle req->gnt latency.
//  BUSY, hold: req[owner]=1 and no expiry -> gnt unchanged, hold_cnt++.
//  BUSY, release: req[owner]=0 at edge, or expiry (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
//   Arbitrate same edge from new ptr. Winner -> gnt=winner, hold_cnt=0, stay BUSY.
//   No bubble between owners. No requester -> gnt=0, IDLE.
//  Expiry: owner holds exactly MAX_HOLD cycles. gnt_frc=1 in the cycle after the expiry edge.
//  Lone requester at expiry: search from owner+1 wraps back to it. It is regranted
//   (gnt unchanged), hold_cnt=0, gnt_frc still pulses.
//  Non-owner req bits may toggle freely; they are sampled only at arbitration edges.
//  MAX_HOLD=0: counter and gnt_frc inert (gnt_frc constant 0). Release only by req drop.
//  hold_cnt width $clog2(MAX_HOLD+1). Saturates; never wraps.
//  gnt always one-hot or zero. gnt_idx and gnt_vld are consistent with gnt every cycle.
// TESTING
//  T1 N=4,MAX_HOLD=0: req=0100 at edge0 -> gnt=0100,idx=2,vld=1 from edge1.
//     req=0 before edge5 -> gnt=0,vld=0 after edge5.
//  T2 N=4,MAX_HOLD=4: req=1111 steady from reset -> owners 0,1,2,3,0.
//     4 cycles each, no gap, gnt_frc pulse at each switch.
//  T3 MAX_HOLD=0, owner=1, req=1001 when req[1] drops -> next gnt=1000 (idx 3), no idle cycle.
//  T4 MAX_HOLD=4, req=0001 steady -> gnt=0001 continuous, gnt_frc pulses every 4 cycles.
//  T5 owner=2 mid-hold, pulse rst_n low asynchronously -> outputs 0 without clock.
//     Release with req=1010 -> gnt=0010 one edge later (ptr=0).
//  T6 MAX_HOLD=0, req=1111 held 100 cycles -> gnt stays 0001, gnt_frc never set.
//     Random-req soak asserts one-hot, idx==enc(gnt), and no requester waits >N_REQ grants.

Source files
------------

// File: rtl/gen_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gen_rr_arb (with gen_enc_top one-hot encoder)                   |
// | Brief    : Round-robin arbiter with grant lock and optional hold limit.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module gen_enc_top #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_oh,
  output logic [W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_oh[i]) o_idx = o_idx | W'(i);
    end
  end

endmodule

module gen_rr_arb #(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 0,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_frc
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_vld;
  logic             r_frc;
  logic [IDX_W-1:0] r_ptr;

  logic [IDX_W-1:0] w_own;
  logic [IDX_W-1:0] w_own_nxt;
  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W:0]   w_sum;
  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_win_oh;
  logic             w_win_vld;
  logic             w_busy;
  logic             w_expiry;
  logic             w_release;

  gen_enc_top #(
    .N (N_REQ),
    .W (IDX_W)
  ) u_enc (
    .i_oh  (r_gnt),
    .o_idx (w_own)
  );

  assign w_busy    = (r_state == ST_BUSY);
  assign w_own_nxt = (w_own == IDX_W'(N_REQ - 1)) ? '0 : w_own + 1'b1;

  // A releasing owner searches from owner+1 in the same edge, so the new ptr is used directly.
  assign w_base = w_busy ? w_own_nxt : r_ptr;
  assign w_rot  = N_REQ'({req, req} >> w_base);

  always_comb begin
    w_win_vld = 1'b0;
    w_off     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_win_vld = 1'b1;
        w_off     = IDX_W'(k);
      end
    end
  end

  assign w_sum     = {1'b0, w_base} + {1'b0, w_off};
  assign w_win_idx = (w_sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                                                  : IDX_W'(w_sum);
  assign w_win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_release = w_busy && (!req[w_own] || w_expiry);

  generate
    if (MAX_HOLD > 0) begin : g_hold
      localparam int HCW = $clog2(MAX_HOLD + 1);
      localparam logic [HCW-1:0] c_last = HCW'(MAX_HOLD - 1);
      logic [HCW-1:0] r_hold;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hold <= '0;
        end else if (!w_busy || w_release) begin
          r_hold <= '0;
        end else if (r_hold != {HCW{1'b1}}) begin
          r_hold <= r_hold + 1'b1;
        end
      end

      assign w_expiry = w_busy && (r_hold == c_last);
    end else begin : g_no_hold
      assign w_expiry = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_vld   <= 1'b0;
      r_frc   <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_frc <= w_expiry;
      if (!w_busy || w_release) begin
        if (w_busy) r_ptr <= w_own_nxt;
        r_gnt   <= w_win_vld ? w_win_oh : '0;
        r_vld   <= w_win_vld;
        r_state <= w_win_vld ? ST_BUSY : ST_IDLE;
      end
    end
  end

  assign gnt     = r_gnt;
  assign gnt_vld = r_vld;
  assign gnt_idx = w_own;
  assign gnt_frc = r_frc;

endmodule
`default_nettype wire

// File: tb/tb_gen_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gen_rr_arb                                                   |
// | Brief    : Scoreboard bench for gen_rr_arb, unlimited and MAX_HOLD=4 DUTs. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module tb_gen_rr_arb;

  typedef struct packed {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
    logic       frc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt0, gnt1;
  logic       vld0, vld1;
  logic [1:0] idx0, idx1;
  logic       frc0, frc1;

  int tot = 0;
  int bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: owner index (-1 = none), search start, cycles held so far.
  int m_own[2];
  int m_ptr[2];
  int m_cnt[2];
  int mh[2] = '{0, 4};

  gen_rr_arb #(.N_REQ(4), .MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt0), .gnt_vld(vld0), .gnt_idx(idx0), .gnt_frc(frc0)
  );

  gen_rr_arb #(.N_REQ(4), .MAX_HOLD(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt1), .gnt_vld(vld1), .gnt_idx(idx1), .gnt_frc(frc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tot++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int search(input int base, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] v;
    v = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) v = 2'(i);
    return v;
  endfunction

  task automatic model_step(input int d, input logic [3:0] r, output exp_t e);
    bit frc;
    int w;
    frc = 1'b0;
    if (m_own[d] < 0) begin
      w = search(m_ptr[d], r);
      if (w >= 0) begin
        m_own[d] = w;
        m_cnt[d] = 1;
      end
    end else begin
      frc = (mh[d] != 0) && (m_cnt[d] == mh[d]);
      if (!r[m_own[d]] || frc) begin
        m_ptr[d] = (m_own[d] + 1) % 4;
        w = search(m_ptr[d], r);
        if (w >= 0) begin
          m_own[d] = w;
          m_cnt[d] = 1;
        end else begin
          m_own[d] = -1;
        end
      end else begin
        m_cnt[d]++;
      end
    end
    e.vld = (m_own[d] >= 0);
    e.gnt = e.vld ? 4'(1 << m_own[d]) : 4'd0;
    e.idx = e.vld ? 2'(m_own[d]) : 2'd0;
    e.frc = frc;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1;
      m_ptr[d] = 0;
      m_cnt[d] = 0;
    end
  endtask

  task automatic cyc(input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    req   = r;
    model_step(0, r, e);
    q0.push_back(e);
    model_step(1, r, e);
    q1.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt0"}, gnt0, 0);
    chk({tag, "_vld0"}, vld0, 0);
    chk({tag, "_idx0"}, idx0, 0);
    chk({tag, "_frc0"}, frc0, 0);
    chk({tag, "_gnt1"}, gnt1, 0);
    chk({tag, "_vld1"}, vld1, 0);
    chk({tag, "_idx1"}, idx1, 0);
    chk({tag, "_frc1"}, frc1, 0);
  endtask

  // Asserts reset mid-cycle (no clock edge in between) and checks outputs clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
  endtask

  // Monitor: pops one expectation per DUT per clock and checks structural invariants.
  initial begin
    exp_t       e;
    logic [3:0] prev1;
    int         wt[4];
    bit         ev;
    prev1 = 4'd0;
    for (int i = 0; i < 4; i++) wt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev1 = 4'd0;
        for (int i = 0; i < 4; i++) wt[i] = 0;
      end
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("d0_gnt", gnt0, e.gnt);
        chk("d0_vld", vld0, e.vld);
        chk("d0_idx", idx0, e.idx);
        chk("d0_frc", frc0, e.frc);
        chk("d0_onehot", $onehot0(gnt0), 1);
        chk("d0_idx_enc", idx0, enc(gnt0));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("d1_gnt", gnt1, e.gnt);
        chk("d1_vld", vld1, e.vld);
        chk("d1_idx", idx1, e.idx);
        chk("d1_frc", frc1, e.frc);
        chk("d1_onehot", $onehot0(gnt1), 1);
        chk("d1_idx_enc", idx1, enc(gnt1));
        ev = vld1 && ((gnt1 != prev1) || frc1);
        for (int i = 0; i < 4; i++) begin
          if (!req[i] || gnt1[i]) begin
            wt[i] = 0;
          end else if (ev) begin
            wt[i]++;
            chk("d1_starve", (wt[i] > 4) ? 1 : 0, 0);
          end
        end
        prev1 = gnt1;
      end
    end
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    req   = 4'd0;
    model_reset();
    #7 check_zero("reset");

    // Single requester, then drop.
    repeat (5) cyc(4'b0100);
    repeat (2) cyc(4'b0000);

    // All requesting: rotation under the hold limit, permanent lock without it.
    do_reset();
    repeat (20) cyc(4'b1111);

    // Owner 1 drops while 0 and 3 request: next owner 3, no idle cycle.
    do_reset();
    repeat (2) cyc(4'b0010);
    repeat (2) cyc(4'b1001);
    cyc(4'b0000);

    // Lone requester is regranted at each expiry.
    do_reset();
    repeat (14) cyc(4'b0001);

    // Async reset while owner 2 holds, then ptr restarts at 0.
    do_reset();
    repeat (2) cyc(4'b0100);
    do_reset();
    repeat (2) cyc(4'b1010);

    do_reset();
    repeat (100) cyc(4'b1111);

    // Random soak: each request bit flips with probability 1/4 per cycle.
    r = 4'($urandom);
    repeat (400) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
      end
      cyc(r);
    end

    @(posedge clk);
    #3 chk("queue_drained", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
`default_nettype wire
